// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
//   Plays an N-bit target pattern LSB first into a downstream JK flip-flop.
//   For each bit it drives the J/K pair that moves the flip-flop from its
//   modelled state to the target bit. It also checks the fed-back Q against
//   the expected sequence and counts the bits that differ.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset (share with the downstream FF)
//   enable_i     advance qualifier; 0 freezes all state and forces J=K=0
//   start_i      play request, honoured only in idle
//   pattern_i    target bits, bit 0 played first, latched on acceptance
//   q_fb_i       Q of the downstream JK flip-flop
//   j_o, k_o     J/K drive to the downstream flip-flop
//   busy_o       high while playing bits or doing the final check
//   done_o       one-cycle completion pulse
//   mismatch_o   sticky: some compared bit differed in the current/last run
//   err_count_o  number of mismatching bits in the current/last run
module jk_excitation_driver #(
  parameter int unsigned N          = 8,
  parameter bit          USE_TOGGLE = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   start_i,
  input  logic [N-1:0]           pattern_i,
  input  logic                   q_fb_i,
  output logic                   j_o,
  output logic                   k_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   mismatch_o,
  output logic [$clog2(N+1)-1:0] err_count_o
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

  state_e            state_q;
  logic [N-1:0]      pat_q;
  logic [IdxW-1:0]   idx_q;
  logic              model_q;     // expected Q of the downstream flip-flop
  logic              mismatch_q;
  logic [CntW-1:0]   err_q;

  logic              cur_bit;
  logic [IdxW-1:0]   idx_prev;
  logic              last_idx;
  logic              cmp_en;
  logic              cmp_ref;
  logic              miss;

  assign cur_bit  = pat_q[idx_q];
  assign idx_prev = idx_q - IdxW'(1);
  assign last_idx = (idx_q == IdxW'(N - 1));

  // The flip-flop output seen at an edge reflects the bit driven in the
  // preceding cycle, so RUN checks the previous bit and CHECK the last one.
  always_comb begin
    cmp_en  = 1'b0;
    cmp_ref = 1'b0;
    unique case (state_q)
      StRun: begin
        cmp_en  = (idx_q != '0);
        cmp_ref = pat_q[idx_prev];
      end
      StCheck: begin
        cmp_en  = 1'b1;
        cmp_ref = pat_q[N-1];
      end
      default: ;
    endcase
  end

  assign miss = cmp_en & (q_fb_i != cmp_ref);

  // J/K only move the flip-flop when the model differs from the target bit.
  always_comb begin
    j_o = 1'b0;
    k_o = 1'b0;
    if (enable_i && (state_q == StRun) && (model_q != cur_bit)) begin
      if (USE_TOGGLE) begin
        j_o = 1'b1;
        k_o = 1'b1;
      end else begin
        j_o = cur_bit;
        k_o = ~cur_bit;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pat_q      <= '0;
      idx_q      <= '0;
      model_q    <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else if (enable_i) begin
      if (miss) begin
        mismatch_q <= 1'b1;
        err_q      <= err_q + CntW'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            pat_q      <= pattern_i;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          model_q <= cur_bit;
          if (last_idx) begin
            state_q <= StCheck;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StCheck: state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = (state_q == StRun) || (state_q == StCheck);
  assign done_o      = (state_q == StDone);
  assign mismatch_o  = mismatch_q;
  assign err_count_o = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two instances (set/clear and toggle
// encodings) share stimulus, each looped back through its own behavioural
// JK flip-flop. Feedback can be forced to 0 to emulate a stuck flip-flop.
module tb_jk_excitation_driver;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       start;
  logic [7:0] pattern;
  logic       stuck;

  logic       j0, k0, busy0, done0, mm0;
  logic [3:0] err0;
  logic       j1, k1, busy1, done1, mm1;
  logic [3:0] err1;
  logic       ff0, ff1;
  logic       qfb0, qfb1;

  int n_total = 0;
  int n_bad   = 0;

  assign qfb0 = stuck ? 1'b0 : ff0;
  assign qfb1 = stuck ? 1'b0 : ff1;

  jk_excitation_driver #(.N(8), .USE_TOGGLE(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .start_i(start),
    .pattern_i(pattern), .q_fb_i(qfb0), .j_o(j0), .k_o(k0), .busy_o(busy0),
    .done_o(done0), .mismatch_o(mm0), .err_count_o(err0)
  );

  jk_excitation_driver #(.N(8), .USE_TOGGLE(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .start_i(start),
    .pattern_i(pattern), .q_fb_i(qfb1), .j_o(j1), .k_o(k1), .busy_o(busy1),
    .done_o(done1), .mismatch_o(mm1), .err_count_o(err1)
  );

  // Behavioural downstream JK flip-flops sharing clock and reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff0 <= 1'b0;
      ff1 <= 1'b0;
    end else begin
      case ({j0, k0})
        2'b10:   ff0 <= 1'b1;
        2'b01:   ff0 <= 1'b0;
        2'b11:   ff0 <= ~ff0;
        default: ff0 <= ff0;
      endcase
      case ({j1, k1})
        2'b10:   ff1 <= 1'b1;
        2'b01:   ff1 <= 1'b0;
        2'b11:   ff1 <= ~ff1;
        default: ff1 <= ff1;
      endcase
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One full run. jk0/jk1 hold the expected {J,K} of bit k at [2k+1:2k].
  // exp_edges counts enabled-or-not edges from E0 (inclusive) to the edge
  // after which done is visible.
  task automatic play(input string name, input logic [7:0] pat,
                      input logic [15:0] jk0, input logic [15:0] jk1,
                      input int exp_err, input int exp_edges,
                      input int gap_at, input bit poke_start);
    int edges;
    pattern = pat;
    start   = 1'b1;
    enable  = 1'b1;
    tick();
    edges   = 1;
    start   = 1'b0;
    pattern = 8'h5A;  // late change must not affect the run
    for (int k = 0; k < 8; k++) begin
      if (k == gap_at) begin
        enable = 1'b0;
        for (int g = 0; g < 3; g++) begin
          #1;
          check($sformatf("%s gap%0d jk", name, g), {j0, k0, j1, k1}, 4'b0000);
          check($sformatf("%s gap%0d busy", name, g), busy0, 1'b1);
          tick();
          edges++;
        end
        enable = 1'b1;
        #1;
      end
      check($sformatf("%s jk0 bit%0d", name, k), {j0, k0}, jk0[2*k +: 2]);
      check($sformatf("%s jk1 bit%0d", name, k), {j1, k1}, jk1[2*k +: 2]);
      if (k == 0) check($sformatf("%s busy run", name), busy0, 1'b1);
      if (poke_start && k == 3) begin
        start   = 1'b1;
        pattern = 8'hFF;
      end
      tick();
      edges++;
      start = 1'b0;
    end
    check($sformatf("%s check jk", name), {j0, k0, j1, k1}, 4'b0000);
    check($sformatf("%s check busy", name), {busy0, done0}, 2'b10);
    tick();
    edges++;
    check($sformatf("%s done", name), {busy0, done0}, 2'b01);
    check($sformatf("%s latency", name), edges, exp_edges);
    check($sformatf("%s err0", name), err0, exp_err);
    check($sformatf("%s mm0", name), mm0, (exp_err != 0));
    check($sformatf("%s err1", name), err1, exp_err);
    // start in the done cycle is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("%s idle after done", name), {busy0, done0, busy1, done1}, 4'b0000);
  endtask

  initial begin
    bit saw_done;
    rst_n   = 1'b0;
    enable  = 1'b0;
    start   = 1'b0;
    pattern = 8'h00;
    stuck   = 1'b0;
    #1;
    check("reset outs", {j0, k0, busy0, done0, mm0, err0}, 9'd0);
    check("reset outs tgl", {j1, k1, busy1, done1, mm1, err1}, 9'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Loopback, both encodings.
    play("loop", 8'b1011_0010, 16'b10_01_00_10_00_01_10_00,
         16'b11_11_00_11_00_11_11_00, 0, 10, -1, 1'b0);

    // Stuck-at-0 feedback: bits 1, 4, 5, 7 differ.
    do_reset();
    stuck = 1'b1;
    play("stuck", 8'b1011_0010, 16'b10_01_00_10_00_01_10_00,
         16'b11_11_00_11_00_11_11_00, 4, 10, -1, 1'b0);

    // Reset mid-run at i=3, with the model left at 1 and a mismatch logged.
    do_reset();
    pattern = 8'b0000_0110;
    start   = 1'b1;
    enable  = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e < 3; e++) tick();
    check("abort pre jk", {j0, k0}, 2'b01);
    check("abort pre mm", {mm0, err0}, 5'b1_0001);
    rst_n = 1'b0;
    #1;
    check("abort outs", {j0, k0, busy0, done0, mm0, err0}, 9'd0);
    check("abort outs tgl", {j1, k1, busy1, done1, mm1, err1}, 9'd0);
    tick();
    rst_n = 1'b1;
    stuck = 1'b0;
    saw_done = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (done0 || done1) saw_done = 1'b1;
    end
    check("abort no done", saw_done, 1'b0);
    play("post", 8'b1011_0010, 16'b10_01_00_10_00_01_10_00,
         16'b11_11_00_11_00_11_11_00, 0, 10, -1, 1'b0);

    // Enable gap of 3 cycles at bit 2.
    do_reset();
    play("gap", 8'b1011_0010, 16'b10_01_00_10_00_01_10_00,
         16'b11_11_00_11_00_11_11_00, 0, 13, 2, 1'b0);

    // start pulse while busy with pattern 8'hFF.
    do_reset();
    play("poke", 8'b1011_0010, 16'b10_01_00_10_00_01_10_00,
         16'b11_11_00_11_00_11_11_00, 0, 10, -1, 1'b1);

    // Model persists across runs.
    do_reset();
    play("p80", 8'h80, 16'b10_00_00_00_00_00_00_00,
         16'b11_00_00_00_00_00_00_00, 0, 10, -1, 1'b0);
    play("p00", 8'h00, 16'b00_00_00_00_00_00_00_01,
         16'b00_00_00_00_00_00_00_11, 0, 10, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
